// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared image dimensions, widths and coefficient map for the CNN front end
package cnn_pkg;
    localparam int IMG_W          = 28;
    localparam int IMG_H          = 28;
    localparam int Px_W           = 8;
    localparam int Wt_W           = 8;
    localparam int In_d_W         = 32;
    localparam int COEF_BIAS_ADDR = 9;
    localparam int KERNEL_TAPS    = 9;

    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    // Zero-extended pixel (Px_W+1 signed) times signed coefficient.
    localparam int PROD_W = Px_W + Wt_W + 1;
endpackage

// File: rtl/conv3x3_line_buffer.sv
// rtl/conv3x3_line_buffer.sv - one image row of pixels, registered write, combinational read
// Ports: clk, clr (sync active-high, clears every entry), we/addr/wdata write side,
//        rdata = current contents at addr (old value on the cycle it is overwritten).
module line_buffer
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [COL_W-1:0] addr,
    input  logic [Px_W-1:0]  wdata,
    output logic [Px_W-1:0]  rdata
);
    logic [Px_W-1:0] mem [IMG_W];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < IMG_W; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 valid-mode convolution, raster in, raster out
// Ports: clk, clr (sync active-high); w_we/w_addr/w_data coefficient writes
//        (0..8 kernel, 9 bias, 10..15 ignored); in_valid/in_data pixel beats, no backpressure;
//        out_valid one-cycle strobe, out_data signed result held between strobes.
module conv3x3_stream
    import cnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     w_we,
    input  logic [3:0]               w_addr,
    input  logic signed [Wt_W-1:0]   w_data,
    input  logic                     in_valid,
    input  logic [Px_W-1:0]          in_data,
    output logic                     out_valid,
    output logic signed [In_d_W-1:0] out_data
);
    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic [Px_W-1:0]          lb0_rd, lb1_rd;
    logic [Px_W-1:0]          win [3][3];
    logic signed [Wt_W-1:0]   kern [KERNEL_TAPS];
    logic signed [Wt_W-1:0]   bias;
    logic                     v0, v1;
    logic signed [PROD_W-1:0] prod      [KERNEL_TAPS];
    logic signed [PROD_W-1:0] prod_next [KERNEL_TAPS];
    logic signed [In_d_W-1:0] acc;
    logic                     completing;

    assign completing = in_valid && (row >= ROW_W'(2)) && (col >= COL_W'(2));

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < KERNEL_TAPS; i++) begin
                kern[i] <= '0;
            end
            bias <= '0;
        end else if (w_we && (w_addr <= 4'(COEF_BIAS_ADDR))) begin
            if (w_addr == 4'(COEF_BIAS_ADDR)) begin
                bias <= w_data;
            end else begin
                kern[w_addr] <= w_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (col == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // lb1 holds the previous row, lb0 the one before; reads see pre-write contents.
    line_buffer u_lb1 (
        .clk   (clk),
        .clr   (clr),
        .we    (in_valid),
        .addr  (col),
        .wdata (in_data),
        .rdata (lb1_rd)
    );

    line_buffer u_lb0 (
        .clk   (clk),
        .clr   (clr),
        .we    (in_valid),
        .addr  (col),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    // Window row 0 is the oldest image row; column 2 is the newest pixel column.
    // v0 marks that the window now holds a complete, legal 3x3 neighbourhood.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
            v0 <= 1'b0;
        end else begin
            v0 <= completing;
            if (in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb0_rd;
                win[1][2] <= lb1_rd;
                win[2][2] <= in_data;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < KERNEL_TAPS; i++) begin
            prod_next[i] = '0;
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                prod_next[r*3+c] = PROD_W'($signed({1'b0, win[r][c]})) * PROD_W'(kern[r*3+c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            v1 <= 1'b0;
            for (int i = 0; i < KERNEL_TAPS; i++) begin
                prod[i] <= '0;
            end
        end else begin
            v1 <= v0;
            if (v0) begin
                prod <= prod_next;
            end
        end
    end

    always_comb begin
        acc = {{(In_d_W-Wt_W){bias[Wt_W-1]}}, bias};
        for (int i = 0; i < KERNEL_TAPS; i++) begin
            acc = acc + {{(In_d_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                out_data <= acc;
            end
        end
    end
endmodule
